// File: rtl/skin_frame_tracker.sv
// Frame-level sequencer for the skin classification stream: tracks raster position,
// accumulates per-frame class counts and the skin bounding box, and reports one record per frame.
module skin_frame_tracker #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned MIN_PIXELS = 256,
    parameter int unsigned CW         = 19
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic          iFrameStart,
    input  logic          iDVAL,
    input  logic [1:0]    iIsSkin,
    input  logic          iResultAck,
    output logic          oBusy,
    output logic          oResultValid,
    output logic [CW-1:0] oSkinCount,
    output logic [CW-1:0] oGreenCount,
    output logic [9:0]    oXmin,
    output logic [9:0]    oXmax,
    output logic [9:0]    oYmin,
    output logic [9:0]    oYmax,
    output logic          oBoxValid,
    output logic [7:0]    oDropCount
);

    localparam int unsigned XW = 10;

    typedef enum logic [1:0] {IDLE, ACTIVE, RESULT} state_t;

    state_t        state;
    logic [XW-1:0] x, y;
    logic [XW-1:0] xmin, xmax, ymin, ymax;
    logic [CW-1:0] skin_acc, green_acc;

    logic [CW-1:0] skin_nxt, green_nxt;
    logic [XW-1:0] xmin_nxt, xmax_nxt, ymin_nxt, ymax_nxt;
    logic          last_px, box_ok, clr;

    assign oBusy        = (state == ACTIVE);
    assign oResultValid = (state == RESULT);

    // Candidate accumulator/box values if the current pixel is accepted
    always_comb begin
        skin_nxt  = skin_acc + CW'(iIsSkin[1]);
        green_nxt = green_acc + CW'(iIsSkin[0]);
        xmin_nxt  = xmin;
        xmax_nxt  = xmax;
        ymin_nxt  = ymin;
        ymax_nxt  = ymax;
        if (iIsSkin[1]) begin
            if (x < xmin) xmin_nxt = x;
            if (x > xmax) xmax_nxt = x;
            if (y < ymin) ymin_nxt = y;
            if (y > ymax) ymax_nxt = y;
        end
        last_px = (x == XW'(H_ACTIVE - 1)) && (y == XW'(V_ACTIVE - 1));
        box_ok  = (skin_nxt >= CW'(MIN_PIXELS));
        clr     = iFrameStart && ((state == IDLE) || (state == ACTIVE) ||
                                  ((state == RESULT) && iResultAck));
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state       <= IDLE;
            x           <= '0;
            y           <= '0;
            skin_acc    <= '0;
            green_acc   <= '0;
            xmin        <= '1;
            xmax        <= '0;
            ymin        <= '1;
            ymax        <= '0;
            oSkinCount  <= '0;
            oGreenCount <= '0;
            oXmin       <= '0;
            oXmax       <= '0;
            oYmin       <= '0;
            oYmax       <= '0;
            oBoxValid   <= 1'b0;
            oDropCount  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (iFrameStart) state <= ACTIVE;
                end
                ACTIVE: begin
                    if (!iFrameStart && iDVAL) begin
                        skin_acc  <= skin_nxt;
                        green_acc <= green_nxt;
                        xmin      <= xmin_nxt;
                        xmax      <= xmax_nxt;
                        ymin      <= ymin_nxt;
                        ymax      <= ymax_nxt;
                        if (x == XW'(H_ACTIVE - 1)) begin
                            x <= '0;
                            y <= y + XW'(1);
                        end else begin
                            x <= x + XW'(1);
                        end
                        if (last_px) begin
                            state       <= RESULT;
                            oSkinCount  <= skin_nxt;
                            oGreenCount <= green_nxt;
                            oBoxValid   <= box_ok;
                            oXmin       <= box_ok ? xmin_nxt : '0;
                            oXmax       <= box_ok ? xmax_nxt : '0;
                            oYmin       <= box_ok ? ymin_nxt : '0;
                            oYmax       <= box_ok ? ymax_nxt : '0;
                        end
                    end
                end
                RESULT: begin
                    if (iResultAck) begin
                        state <= iFrameStart ? ACTIVE : IDLE;
                    end else if (iFrameStart && (oDropCount != 8'hFF)) begin
                        oDropCount <= oDropCount + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase

            // Frame (re)start overrides any accumulation on the same cycle
            if (clr) begin
                x         <= '0;
                y         <= '0;
                skin_acc  <= '0;
                green_acc <= '0;
                xmin      <= '1;
                xmax      <= '0;
                ymin      <= '1;
                ymax      <= '0;
            end
        end
    end

endmodule

// File: tb/tb_skin_frame_tracker.sv
// Scoreboard bench for skin_frame_tracker on an 8x4 raster with MIN_PIXELS=3.
module tb_skin_frame_tracker;

    localparam int unsigned H  = 8;
    localparam int unsigned V  = 4;
    localparam int unsigned MP = 3;
    localparam int unsigned CW = 19;
    localparam int unsigned NP = H * V;

    typedef logic [2*CW+40:0] rec_t;

    logic          iCLK = 1'b0;
    logic          iRST, iFrameStart, iDVAL, iResultAck;
    logic [1:0]    iIsSkin;
    logic          oBusy, oResultValid, oBoxValid;
    logic [CW-1:0] oSkinCount, oGreenCount;
    logic [9:0]    oXmin, oXmax, oYmin, oYmax;
    logic [7:0]    oDropCount;

    int   n_cmp  = 0;
    int   n_fail = 0;
    rec_t sb[$];
    logic [1:0] pix [NP];

    skin_frame_tracker #(.H_ACTIVE(H), .V_ACTIVE(V), .MIN_PIXELS(MP), .CW(CW)) dut (
        .iCLK(iCLK), .iRST(iRST), .iFrameStart(iFrameStart), .iDVAL(iDVAL),
        .iIsSkin(iIsSkin), .iResultAck(iResultAck), .oBusy(oBusy),
        .oResultValid(oResultValid), .oSkinCount(oSkinCount), .oGreenCount(oGreenCount),
        .oXmin(oXmin), .oXmax(oXmax), .oYmin(oYmin), .oYmax(oYmax),
        .oBoxValid(oBoxValid), .oDropCount(oDropCount)
    );

    always #5 iCLK = ~iCLK;

    function automatic rec_t dut_rec();
        return {oSkinCount, oGreenCount, oXmin, oXmax, oYmin, oYmax, oBoxValid};
    endfunction

    // Reference result computed directly from the pixel table
    function automatic rec_t model_rec();
        int sk = 0, gr = 0, xmn = 1023, xmx = 0, ymn = 1023, ymx = 0;
        bit bv;
        for (int i = 0; i < int'(NP); i++) begin
            int px = i % int'(H);
            int py = i / int'(H);
            if (pix[i][1]) begin
                sk++;
                if (px < xmn) xmn = px;
                if (px > xmx) xmx = px;
                if (py < ymn) ymn = py;
                if (py > ymx) ymx = py;
            end
            if (pix[i][0]) gr++;
        end
        bv = (sk >= int'(MP));
        if (!bv) begin xmn = 0; xmx = 0; ymn = 0; ymx = 0; end
        return {CW'(sk), CW'(gr), 10'(xmn), 10'(xmx), 10'(ymn), 10'(ymx), bv};
    endfunction

    task automatic clear_pix(input logic [1:0] v);
        for (int i = 0; i < int'(NP); i++) pix[i] = v;
    endtask

    task automatic pulse_start();
        iFrameStart = 1'b1;
        @(negedge iCLK);
        iFrameStart = 1'b0;
    endtask

    task automatic pulse_ack();
        iResultAck = 1'b1;
        @(negedge iCLK);
        iResultAck = 1'b0;
    endtask

    task automatic pulse_rst();
        iRST = 1'b1;
        @(negedge iCLK);
        iRST = 1'b0;
    endtask

    task automatic drive_pixels(input int n, input int gapmax, input logic busy);
        int g;
        for (int i = 0; i < n; i++) begin
            g = (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0;
            repeat (g) begin
                iDVAL = 1'b0;
                @(negedge iCLK);
                n_cmp++;
                if (oBusy !== busy) begin
                    n_fail++;
                    $display("FAIL busy_gap: oBusy=%b required %b", oBusy, busy);
                end
            end
            iDVAL   = 1'b1;
            iIsSkin = pix[i % int'(NP)];
            @(negedge iCLK);
            if (i < n - 1 || n < int'(NP)) begin
                n_cmp++;
                if (oBusy !== busy) begin
                    n_fail++;
                    $display("FAIL busy_px%0d: oBusy=%b required %b", i, oBusy, busy);
                end
            end
        end
        iDVAL   = 1'b0;
        iIsSkin = 2'b00;
    endtask

    task automatic drive_frame(input int gapmax);
        sb.push_back(model_rec());
        drive_pixels(int'(NP), gapmax, 1'b1);
    endtask

    task automatic test_reset();
        iRST = 1'b1; iFrameStart = 0; iDVAL = 0; iIsSkin = 0; iResultAck = 0;
        repeat (2) @(negedge iCLK);
        iRST = 1'b0;
        @(negedge iCLK);
        n_cmp++;
        if ({oBusy, oResultValid, dut_rec(), oDropCount} !== '0) begin
            n_fail++;
            $display("FAIL reset: busy=%b valid=%b rec=%h drop=%0d required all 0",
                     oBusy, oResultValid, dut_rec(), oDropCount);
        end
    endtask

    task automatic test_basic_frame(input int gapmax, input string nm);
        rec_t e;
        clear_pix(2'b00);
        pix[1*H+2] = 2'b10; pix[1*H+5] = 2'b10; pix[3*H+3] = 2'b10;
        pulse_start();
        n_cmp++;
        if (oBusy !== 1'b1) begin n_fail++; $display("FAIL %s_start: oBusy=%b required 1", nm, oBusy); end
        drive_frame(gapmax);
        n_cmp++;
        if (oResultValid !== 1'b1 || oBusy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_latency: valid=%b busy=%b required 1/0", nm, oResultValid, oBusy);
        end
        e = sb.pop_front();
        n_cmp++;
        if (dut_rec() !== e) begin n_fail++; $display("FAIL %s_rec: got %h required %h", nm, dut_rec(), e); end
        n_cmp++;
        if ({oSkinCount, oXmin, oXmax, oYmin, oYmax, oBoxValid} !== {CW'(3), 10'd2, 10'd5, 10'd1, 10'd3, 1'b1}) begin
            n_fail++;
            $display("FAIL %s_box: skin=%0d x=%0d..%0d y=%0d..%0d bv=%b required 3 2..5 1..3 1",
                     nm, oSkinCount, oXmin, oXmax, oYmin, oYmax, oBoxValid);
        end
        pulse_ack();
        n_cmp++;
        if (oResultValid !== 1'b0) begin n_fail++; $display("FAIL %s_ack: valid=%b required 0", nm, oResultValid); end
    endtask

    task automatic test_small_box();
        rec_t e;
        clear_pix(2'b01);
        pix[4] = 2'b11; pix[30] = 2'b11;
        pulse_start();
        drive_frame(0);
        e = sb.pop_front();
        n_cmp++;
        if (oResultValid !== 1'b1 || dut_rec() !== e) begin
            n_fail++;
            $display("FAIL small_box: valid=%b got %h required %h", oResultValid, dut_rec(), e);
        end
        n_cmp++;
        if ({oSkinCount, oGreenCount, oBoxValid, oXmin, oXmax, oYmin, oYmax} !== {CW'(2), CW'(32), 41'd0}) begin
            n_fail++;
            $display("FAIL small_box_fields: skin=%0d green=%0d bv=%b required 2 32 0", oSkinCount, oGreenCount, oBoxValid);
        end
        pulse_ack();
    endtask

    task automatic test_drop_back_to_back();
        rec_t e, held;
        clear_pix(2'b00);
        pix[0] = 2'b10; pix[7] = 2'b10; pix[31] = 2'b10;
        pulse_start();
        drive_frame(0);
        e = sb.pop_front();
        held = dut_rec();
        n_cmp++;
        if (held !== e) begin n_fail++; $display("FAIL drop_first: got %h required %h", held, e); end
        for (int k = 0; k < 2; k++) begin
            iDVAL = 1'b1; iIsSkin = 2'b11;
            pulse_start();
            repeat (3) @(negedge iCLK);
            iDVAL = 1'b0;
        end
        n_cmp++;
        if (oDropCount !== 8'd2 || oResultValid !== 1'b1 || dut_rec() !== held) begin
            n_fail++;
            $display("FAIL drop_hold: drop=%0d valid=%b rec=%h required 2 1 %h", oDropCount, oResultValid, dut_rec(), held);
        end
        iResultAck = 1'b1; iFrameStart = 1'b1;
        @(negedge iCLK);
        iResultAck = 1'b0; iFrameStart = 1'b0;
        n_cmp++;
        if (oBusy !== 1'b1 || oResultValid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b: busy=%b valid=%b required 1/0", oBusy, oResultValid);
        end
        clear_pix(2'b01);
        pix[9] = 2'b10; pix[14] = 2'b11; pix[22] = 2'b10; pix[17] = 2'b10;
        drive_frame(1);
        e = sb.pop_front();
        n_cmp++;
        if (oResultValid !== 1'b1 || dut_rec() !== e || oDropCount !== 8'd2) begin
            n_fail++;
            $display("FAIL b2b_rec: valid=%b got %h drop=%0d required 1 %h 2", oResultValid, dut_rec(), oDropCount, e);
        end
        pulse_ack();
    endtask

    task automatic test_abort();
        rec_t e;
        clear_pix(2'b00);
        pix[0] = 2'b10; pix[5] = 2'b01;
        pulse_start();
        drive_pixels(20, 0, 1'b1);
        iFrameStart = 1'b1; iDVAL = 1'b1; iIsSkin = 2'b11;
        @(negedge iCLK);
        iFrameStart = 1'b0; iDVAL = 1'b0; iIsSkin = 2'b00;
        n_cmp++;
        if (oBusy !== 1'b1 || oResultValid !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_state: busy=%b valid=%b required 1/0", oBusy, oResultValid);
        end
        clear_pix(2'b00);
        drive_frame(0);
        e = sb.pop_front();
        n_cmp++;
        if (oResultValid !== 1'b1 || dut_rec() !== e || oSkinCount !== '0 || oGreenCount !== '0) begin
            n_fail++;
            $display("FAIL abort_rec: valid=%b got %h required 1 %h", oResultValid, dut_rec(), e);
        end
        pulse_ack();
    endtask

    task automatic test_reset_mid();
        rec_t e;
        clear_pix(2'b11);
        pulse_start();
        drive_pixels(10, 0, 1'b1);
        iDVAL = 1'b1;
        pulse_rst();
        iDVAL = 1'b0;
        n_cmp++;
        if ({oBusy, oResultValid, dut_rec(), oDropCount} !== '0) begin
            n_fail++;
            $display("FAIL rst_frame: busy=%b valid=%b rec=%h required all 0", oBusy, oResultValid, dut_rec());
        end
        drive_pixels(40, 0, 1'b0);
        n_cmp++;
        if (oResultValid !== 1'b0 || dut_rec() !== '0) begin
            n_fail++;
            $display("FAIL rst_ignore: valid=%b rec=%h required 0 0", oResultValid, dut_rec());
        end
        pulse_start();
        drive_frame(0);
        e = sb.pop_front();
        n_cmp++;
        if (oResultValid !== 1'b1 || dut_rec() !== e) begin
            n_fail++;
            $display("FAIL rst_refill: valid=%b got %h required 1 %h", oResultValid, dut_rec(), e);
        end
        pulse_start();
        n_cmp++;
        if (oDropCount !== 8'd1) begin n_fail++; $display("FAIL rst_drop1: drop=%0d required 1", oDropCount); end
        pulse_rst();
        n_cmp++;
        if ({oBusy, oResultValid, dut_rec(), oDropCount} !== '0) begin
            n_fail++;
            $display("FAIL rst_result: busy=%b valid=%b rec=%h drop=%0d required all 0",
                     oBusy, oResultValid, dut_rec(), oDropCount);
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame(0, "contig");
        test_small_box();
        test_basic_frame(3, "gaps");
        test_drop_back_to_back();
        test_abort();
        test_reset_mid();
        n_cmp++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL sb_empty: %0d left required 0", sb.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/skin_frame_tracker.md
# skin_frame_tracker

Frame-level sequencer for the complexion-detection datapath. It consumes the per-pixel 2-bit skin classification stream alongside the pixel-valid strobe. It tracks raster position, accumulates per-frame class counts and the bounding box of class-1 (skin) pixels, then presents one result record per frame through a valid/ack handshake to the downstream overlay/control logic. It sits between the SDRAM read-side pixel path and the frame-result consumer, and decides which frames are measured, skipped or aborted.

## Interface
- H_ACTIVE, 640, active pixels per line
- V_ACTIVE, 480, active lines per frame
- MIN_PIXELS, 256, minimum class-1 count for a valid bounding box
- CW, 19, width of pixel counters (must hold H_ACTIVE*V_ACTIVE)

Ports:
- iCLK  in  1  sole clock, all logic on rising edge
- iRST  in  1  synchronous, active-high reset
- iFrameStart  in  1  single-cycle pulse, start of a new frame
- iDVAL  in  1  pixel valid; one active pixel per asserted cycle, raster order
- iIsSkin  in  2  classification of current pixel; bit1 = skin, bit0 = green-dominant
- iResultAck  in  1  consumer accepts current result record
- oBusy  out  1  high while in ACTIVE
- oResultValid  out  1  result record valid, held until acknowledged
- oSkinCount  out  CW  class-1 pixel count of the reported frame
- oGreenCount  out  CW  class-0-bit pixel count of the reported frame
- oXmin, oXmax  out  10  bounding-box columns of class-1 pixels
- oYmin, oYmax  out  10  bounding-box rows of class-1 pixels
- oBoxValid  out  1  oSkinCount >= MIN_PIXELS
- oDropCount  out  8  frames skipped because the result was not acknowledged; saturates at 255

## Operation
- States: IDLE, ACTIVE, RESULT.
- IDLE: iFrameStart -> ACTIVE. Clear x/y, both accumulators, xmin/ymin = 1023, xmax/ymax = 0.
- ACTIVE, iDVAL=1:
  - If iIsSkin[1], increment the skin accumulator and update min/max with the current x, y.
  - If iIsSkin[0], increment the green accumulator. Both bits set updates both.
  - Then x++. At x = H_ACTIVE-1, x wraps to 0 and y++.
- ACTIVE, last pixel: iDVAL with x=H_ACTIVE-1 and y=V_ACTIVE-1.
  - Latch all result outputs from the updated accumulators, including that pixel.
  - oBoxValid = (skin count >= MIN_PIXELS).
  - If oBoxValid=0, drive oXmin/oXmax/oYmin/oYmax = 0.
  - Go to RESULT.
- ACTIVE, iFrameStart: abort the current frame, clear accumulators/position, stay ACTIVE. No result is produced and oDropCount is unchanged. iDVAL on the same cycle is ignored.
- RESULT: oResultValid=1 and outputs held stable.
  - iResultAck -> IDLE.
  - iResultAck with iFrameStart on the same cycle -> ACTIVE, with accumulators cleared as in IDLE.
  - iFrameStart without ack: remain in RESULT and increment oDropCount (saturating). That frame's pixels are ignored.
- iDVAL outside ACTIVE is ignored. iResultAck outside RESULT is ignored.
- Arithmetic: counters are unsigned CW bits. Coordinates are 10-bit unsigned. A full frame cannot overflow CW at the default sizes.

## Timing
- Reset (iRST=1 at a clock edge): state IDLE. All outputs 0: oBusy, oResultValid, counts, box, oBoxValid, oDropCount. Reset mid-frame or mid-RESULT discards everything, with no result.
- iFrameStart at edge t (IDLE) -> oBusy=1 from t+1. The first accepted pixel is at t+1 or later.
- Last pixel accepted at edge t -> oResultValid=1 and outputs valid from t+1; oBusy=0 from t+1.
- iResultAck sampled high at edge t while oResultValid=1 -> oResultValid=0 from t+1.
- Back-to-back frames: if ack and iFrameStart coincide, oBusy=1 and oResultValid=0 from the next cycle.
- Result outputs change only on the transition into RESULT, or on reset.

## Test plan
(All with H_ACTIVE=8, V_ACTIVE=4, MIN_PIXELS=3.)
- Reset, then one frame of 32 pixels with iIsSkin=2'b10 only at (2,1), (5,1), (3,3) -> oSkinCount=3, box x 2..5, y 1..3, oBoxValid=1, oResultValid one cycle after the last pixel.
- Frame with 2 skin pixels and 32 pixels of iIsSkin[0]=1 -> oSkinCount=2, oGreenCount=32, oBoxValid=0, box fields 0.
- Gaps in iDVAL, with 0–3 idle cycles between pixels -> same results as contiguous stream; oBusy high throughout.
- Hold iResultAck low across two further iFrameStart pulses -> oDropCount=2 and outputs unchanged. Then ack together with iFrameStart -> next frame measured, oResultValid=0 the following cycle.
- iFrameStart after 20 pixels (skin at 0,0) then full frame without skin -> oSkinCount=0; the aborted frame contributes nothing.
- iRST asserted mid-frame and mid-RESULT -> all outputs 0 next cycle; iDVAL ignored until the next iFrameStart.
